// File: rtl/router_pkg.sv
// Shared constants and helpers for the router output-channel FIFOs.
package router_pkg;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_DEPTH   = 16;
    localparam int DEF_LEN_LSB = 2;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Index bits plus one wrap bit for the default depth.
    localparam int PTR_W = clog2(DEF_DEPTH) + 1;

endpackage

// File: rtl/router_fifo_ptr.sv
// Wrapping FIFO pointer: advances on an accepted access, cleared by reset or flush.
module router_fifo_ptr
    import router_pkg::*;
#(
    parameter int PTR_W_P = PTR_W
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               soft_reset,
    input  logic               inc,
    output logic [PTR_W_P-1:0] ptr
);

    logic [PTR_W_P-1:0] ptr_reg;
    logic [PTR_W_P-1:0] ptr_next;

    always_comb begin
        ptr_next = ptr_reg;
        if (inc) begin
            ptr_next = ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn || soft_reset) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

    assign ptr = ptr_reg;

endmodule

// File: rtl/router_pkt_fifo.sv
// Packet-aware output-channel FIFO: header tagging, packet progress, occupancy and sticky errors.
module router_pkt_fifo
    import router_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int LEN_LSB   = DEF_LEN_LSB,
    parameter int AFULL_LVL = DEPTH - 2
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic                    soft_reset,
    input  logic                    write_enb,
    input  logic                    read_enb,
    input  logic                    lfd_state,
    input  logic [DATA_W-1:0]       data_in,
    output logic [DATA_W-1:0]       data_out,
    output logic                    out_valid,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic [clog2(DEPTH):0]   fill_level,
    output logic [DATA_W-LEN_LSB:0] pkt_remaining,
    output logic                    pkt_done,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int AW  = clog2(DEPTH);
    localparam int FPW = AW + 1;
    localparam int RW  = DATA_W - LEN_LSB + 1;

    logic [FPW-1:0]    wr_ptr;
    logic [FPW-1:0]    rd_ptr;
    logic [FPW-1:0]    used;
    logic [AW-1:0]     wr_idx;
    logic [AW-1:0]     rd_idx;
    logic              wr_acc;
    logic              rd_acc;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  tag_reg;
    logic [DATA_W-1:0] rd_word;
    logic              rd_tag;
    logic [RW-1:0]     hdr_len;

    logic              lfd_q_reg;
    logic [DATA_W-1:0] data_out_reg;
    logic              out_valid_reg;
    logic [FPW-1:0]    fill_reg;
    logic [FPW-1:0]    fill_next;
    logic [RW-1:0]     rem_reg;
    logic              done_reg;
    logic              overflow_reg;
    logic              underflow_reg;

    assign wr_idx = wr_ptr[AW-1:0];
    assign rd_idx = rd_ptr[AW-1:0];

    assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);
    assign empty       = (wr_ptr == rd_ptr);
    assign used        = wr_ptr - rd_ptr;
    assign almost_full = (int'(used) >= AFULL_LVL);

    // A flush cycle swallows any access presented alongside it.
    assign wr_acc = resetn && !soft_reset && write_enb && !full;
    assign rd_acc = resetn && !soft_reset && read_enb && !empty;

    router_fifo_ptr #(.PTR_W_P(FPW)) u_wr_ptr (
        .clock      (clock),
        .resetn     (resetn),
        .soft_reset (soft_reset),
        .inc        (wr_acc),
        .ptr        (wr_ptr)
    );

    router_fifo_ptr #(.PTR_W_P(FPW)) u_rd_ptr (
        .clock      (clock),
        .resetn     (resetn),
        .soft_reset (soft_reset),
        .inc        (rd_acc),
        .ptr        (rd_ptr)
    );

    always_ff @(posedge clock) begin
        if (wr_acc) begin
            mem[wr_idx] <= data_in;
        end
    end

    // Tags live beside the data array so a flush can clear them in one cycle.
    always_ff @(posedge clock) begin
        if (!resetn || soft_reset) begin
            tag_reg <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_acc && (wr_idx == AW'(i))) begin
                    tag_reg[i] <= lfd_q_reg;
                end
            end
        end
    end

    assign rd_word = mem[rd_idx];
    assign rd_tag  = tag_reg[rd_idx];
    // Header length counts payload words plus the trailing parity word.
    assign hdr_len = RW'(rd_word[DATA_W-1:LEN_LSB]) + RW'(1);

    always_comb begin
        fill_next = fill_reg;
        case ({wr_acc, rd_acc})
            2'b10:   fill_next = fill_reg + 1'b1;
            2'b01:   fill_next = fill_reg - 1'b1;
            default: fill_next = fill_reg;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            lfd_q_reg     <= 1'b0;
            data_out_reg  <= '0;
            out_valid_reg <= 1'b0;
            fill_reg      <= '0;
            rem_reg       <= '0;
            done_reg      <= 1'b0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else if (soft_reset) begin
            lfd_q_reg     <= 1'b0;
            data_out_reg  <= '0;
            out_valid_reg <= 1'b0;
            fill_reg      <= '0;
            rem_reg       <= '0;
            done_reg      <= 1'b0;
        end else begin
            lfd_q_reg     <= lfd_state;
            out_valid_reg <= rd_acc;
            fill_reg      <= fill_next;
            done_reg      <= 1'b0;
            if (write_enb && full) begin
                overflow_reg <= 1'b1;
            end
            if (read_enb && empty) begin
                underflow_reg <= 1'b1;
            end
            if (rd_acc) begin
                data_out_reg <= rd_word;
                if (rd_tag) begin
                    rem_reg <= hdr_len;
                end else if (rem_reg != '0) begin
                    rem_reg <= rem_reg - 1'b1;
                    if (rem_reg == RW'(1)) begin
                        done_reg <= 1'b1;
                    end
                end
            end
        end
    end

    assign data_out      = data_out_reg;
    assign out_valid     = out_valid_reg;
    assign fill_level    = fill_reg;
    assign pkt_remaining = rem_reg;
    assign pkt_done      = done_reg;
    assign overflow      = overflow_reg;
    assign underflow     = underflow_reg;

endmodule

// File: tb/tb_router_pkt_fifo.sv
// Self-checking bench: queue-based reference model for the default FIFO plus a wide-config directed run.
module tb_router_pkt_fifo;

    localparam int DW = 8;
    localparam int DP = 16;
    localparam int LL = 2;
    localparam int RW = DW - LL + 1;
    localparam int FW = 5;

    localparam int WDW = 16;
    localparam int WDP = 64;
    localparam int WLL = 4;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          resetn, soft_reset, write_enb, read_enb, lfd_state;
    logic [DW-1:0] data_in, data_out;
    logic          out_valid, full, empty, almost_full, pkt_done, overflow, underflow;
    logic [FW-1:0] fill_level;
    logic [RW-1:0] pkt_remaining;

    logic                 w_resetn, w_soft_reset, w_write_enb, w_read_enb, w_lfd_state;
    logic [WDW-1:0]       w_data_in, w_data_out;
    logic                 w_out_valid, w_full, w_empty, w_almost_full, w_pkt_done, w_overflow, w_underflow;
    logic [6:0]           w_fill_level;
    logic [WDW-WLL:0]     w_pkt_remaining;

    router_pkt_fifo #(.DATA_W(DW), .DEPTH(DP), .LEN_LSB(LL), .AFULL_LVL(DP-2)) u_dut (
        .clock(clock), .resetn(resetn), .soft_reset(soft_reset),
        .write_enb(write_enb), .read_enb(read_enb), .lfd_state(lfd_state),
        .data_in(data_in), .data_out(data_out), .out_valid(out_valid),
        .full(full), .empty(empty), .almost_full(almost_full),
        .fill_level(fill_level), .pkt_remaining(pkt_remaining), .pkt_done(pkt_done),
        .overflow(overflow), .underflow(underflow)
    );

    router_pkt_fifo #(.DATA_W(WDW), .DEPTH(WDP), .LEN_LSB(WLL), .AFULL_LVL(WDP-2)) u_dut_w (
        .clock(clock), .resetn(w_resetn), .soft_reset(w_soft_reset),
        .write_enb(w_write_enb), .read_enb(w_read_enb), .lfd_state(w_lfd_state),
        .data_in(w_data_in), .data_out(w_data_out), .out_valid(w_out_valid),
        .full(w_full), .empty(w_empty), .almost_full(w_almost_full),
        .fill_level(w_fill_level), .pkt_remaining(w_pkt_remaining), .pkt_done(w_pkt_done),
        .overflow(w_overflow), .underflow(w_underflow)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: a queue of {tag, data} entries plus packet/flag state.
    logic [DW:0]   m_q[$];
    bit            m_lfd, m_done, m_ov, m_un, m_valid;
    int            m_rem;
    logic [DW-1:0] m_dout;

    task automatic cycle(input bit rn, input bit sr, input bit we, input bit re,
                         input bit lfd, input logic [DW-1:0] d);
        bit          was_full, was_empty;
        logic [DW:0] item;
        logic [DW-1:0] hdr;
        resetn     = rn;
        soft_reset = sr;
        write_enb  = we;
        read_enb   = re;
        lfd_state  = lfd;
        data_in    = d;
        @(posedge clock);
        if (!rn) begin
            m_q.delete();
            m_lfd = 0; m_rem = 0; m_done = 0; m_ov = 0; m_un = 0; m_valid = 0; m_dout = '0;
        end else if (sr) begin
            m_q.delete();
            m_lfd = 0; m_rem = 0; m_done = 0; m_valid = 0; m_dout = '0;
        end else begin
            was_full  = (m_q.size() == DP);
            was_empty = (m_q.size() == 0);
            m_done  = 0;
            m_valid = 0;
            if (we && was_full)  m_ov = 1;
            if (re && was_empty) m_un = 1;
            if (re && !was_empty) begin
                item    = m_q.pop_front();
                m_dout  = item[DW-1:0];
                m_valid = 1;
                if (item[DW]) begin
                    hdr   = item[DW-1:0];
                    m_rem = int'(hdr >> LL) + 1;
                end else if (m_rem > 0) begin
                    m_rem--;
                    if (m_rem == 0) m_done = 1;
                end
            end
            if (we && !was_full) m_q.push_back({m_lfd, d});
            m_lfd = lfd;
        end
        #1;
        check("data_out",      32'(data_out),      32'(m_dout));
        check("out_valid",     32'(out_valid),     32'(m_valid));
        check("full",          32'(full),          32'(m_q.size() == DP));
        check("empty",         32'(empty),         32'(m_q.size() == 0));
        check("almost_full",   32'(almost_full),   32'(m_q.size() >= DP - 2));
        check("fill_level",    32'(fill_level),    32'(m_q.size()));
        check("pkt_remaining", 32'(pkt_remaining), 32'(m_rem));
        check("pkt_done",      32'(pkt_done),      32'(m_done));
        check("overflow",      32'(overflow),      32'(m_ov));
        check("underflow",     32'(underflow),     32'(m_un));
    endtask

    task automatic w_cycle(input bit rn, input bit we, input bit re, input bit lfd,
                           input logic [WDW-1:0] d);
        w_resetn     = rn;
        w_soft_reset = 1'b0;
        w_write_enb  = we;
        w_read_enb   = re;
        w_lfd_state  = lfd;
        w_data_in    = d;
        @(posedge clock);
        #1;
    endtask

    initial begin
        w_resetn = 1'b0; w_soft_reset = 1'b0; w_write_enb = 1'b0;
        w_read_enb = 1'b0; w_lfd_state = 1'b0; w_data_in = '0;

        // Reset
        cycle(0, 0, 0, 0, 0, '0);
        cycle(0, 0, 0, 0, 0, '0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_data_out", 32'(data_out), 32'd0);

        // Packet flow: header 0x0C -> 3 payload + parity
        cycle(1, 0, 0, 0, 1, '0);
        cycle(1, 0, 1, 0, 0, 8'h0C);
        for (int i = 0; i < 4; i++) cycle(1, 0, 1, 0, 0, 8'(8'h31 + i));
        cycle(1, 0, 0, 1, 0, '0);
        check("hdr_pkt_remaining", 32'(pkt_remaining), 32'd4);
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 1, 0, '0);
        check("pkt_done_5th", 32'(pkt_done), 32'd1);
        check("pkt_fill_zero", 32'(fill_level), 32'd0);

        // Fill, overflow, drain, wrap
        for (int i = 0; i < 16; i++) begin
            cycle(1, 0, 1, 0, 0, 8'($urandom));
            if (i == 12) check("afull_at_13", 32'(almost_full), 32'd0);
            if (i == 13) check("afull_at_14", 32'(almost_full), 32'd1);
        end
        check("full_at_16", 32'(full), 32'd1);
        cycle(1, 0, 1, 0, 0, 8'hEE);
        check("overflow_17th", 32'(overflow), 32'd1);
        for (int i = 0; i < 16; i++) cycle(1, 0, 0, 1, 0, '0);
        for (int i = 0; i < 16; i++) cycle(1, 0, 1, 0, 0, 8'($urandom));
        for (int i = 0; i < 16; i++) cycle(1, 0, 0, 1, 0, '0);

        // Simultaneous read + write at full
        cycle(0, 0, 0, 0, 0, '0);
        for (int i = 0; i < 16; i++) cycle(1, 0, 1, 0, 0, 8'($urandom));
        check("sim_pre_overflow", 32'(overflow), 32'd0);
        cycle(1, 0, 1, 1, 0, 8'h77);
        check("sim_fill_15", 32'(fill_level), 32'd15);
        check("sim_overflow", 32'(overflow), 32'd1);

        // Soft reset with 5 words stored
        cycle(1, 1, 0, 0, 0, '0);
        for (int i = 0; i < 6; i++) cycle(1, 0, 1, 0, 0, 8'(8'hA0 + i));
        cycle(1, 0, 0, 1, 0, '0);
        cycle(1, 1, 1, 1, 0, 8'h55);
        check("sr_empty", 32'(empty), 32'd1);
        check("sr_fill", 32'(fill_level), 32'd0);
        check("sr_data_out", 32'(data_out), 32'd0);
        check("sr_overflow_kept", 32'(overflow), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom % 200) != 0, ($urandom % 50) == 0,
                  ($urandom % 100) < 60, ($urandom % 100) < 55,
                  ($urandom % 8) == 0, 8'($urandom));
        end

        // Wide configuration: DATA_W=16, DEPTH=64, LEN_LSB=4
        w_cycle(0, 0, 0, 0, '0);
        w_cycle(0, 0, 0, 0, '0);
        check("w_rst_empty", 32'(w_empty), 32'd1);
        check("w_rst_fill", 32'(w_fill_level), 32'd0);
        w_cycle(1, 0, 0, 1, '0);
        w_cycle(1, 1, 0, 0, 16'h0050);
        for (int i = 1; i < 63; i++) w_cycle(1, 1, 0, 0, 16'(i));
        check("w_full_at_63", 32'(w_full), 32'd0);
        check("w_fill_63", 32'(w_fill_level), 32'd63);
        w_cycle(1, 1, 0, 0, 16'h1234);
        check("w_full_at_64", 32'(w_full), 32'd1);
        check("w_fill_64", 32'(w_fill_level), 32'd64);
        check("w_afull", 32'(w_almost_full), 32'd1);
        w_cycle(1, 0, 1, 0, '0);
        check("w_hdr_data", 32'(w_data_out), 32'h0050);
        check("w_out_valid", 32'(w_out_valid), 32'd1);
        check("w_pkt_remaining", 32'(w_pkt_remaining), 32'd6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
